// File: rtl/attractor_detector.sv
// Attractor detector: shift history of the last DEPTH states; locks on a fixed point or a limit cycle of period <= DEPTH.
// Outputs are registered and update one cycle after the accepted sample; optional timeout via ATTRACTOR_TIMEOUT_EN.
module attractor_detector #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       restart,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           x,
    output logic                       found,
    output logic [$clog2(DEPTH+1)-1:0] period,
    output logic [CNT_W-1:0]           steps,
    output logic                       timeout,
    output logic                       busy
);
    localparam int PW = $clog2(DEPTH+1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEARCH  = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] hist_q [DEPTH];
    logic [WIDTH-1:0] hist_d [DEPTH];
    logic [DEPTH-1:0] hv_q, hv_d, hv_eff;
    logic [CNT_W-1:0] n_q, n_d, n_cur;
    logic [PW-1:0]    cand_q, cand_d, run_q, run_d, period_q, period_d, k;
    logic             found_q, found_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] lock_ref;
    logic             accept;

    always_comb begin
        accept = in_valid && (restart || state_q != ST_TIMEOUT);
        hv_eff = restart ? '0 : hv_q;
        n_cur  = restart ? '0 : n_q;

        // Descending scan so the smallest matching distance wins.
        k = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hv_eff[i] && hist_q[i] == x) k = PW'(i + 1);
        end

        lock_ref = hist_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (period_q == PW'(i + 1)) lock_ref = hist_q[i];
        end

        state_d   = state_q;
        hist_d    = hist_q;
        hv_d      = hv_q;
        n_d       = n_q;
        cand_d    = cand_q;
        run_d     = run_q;
        found_d   = found_q;
        period_d  = period_q;
        steps_d   = steps_q;
        timeout_d = timeout_q;

        if (restart) begin
            state_d   = ST_SEARCH;
            hv_d      = '0;
            n_d       = '0;
            cand_d    = '0;
            run_d     = '0;
            found_d   = 1'b0;
            period_d  = '0;
            steps_d   = '0;
            timeout_d = 1'b0;
        end

        if (accept) begin
            hist_d[0] = x;
            hv_d[0]   = 1'b1;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
                hv_d[i]   = hv_eff[i-1];
            end
            n_d = (n_cur == '1) ? n_cur : n_cur + 1'b1;

            if (!restart && state_q == ST_LOCKED) begin
                if (x != lock_ref) begin
                    state_d  = ST_SEARCH;
                    found_d  = 1'b0;
                    period_d = '0;
                    cand_d   = '0;
                    run_d    = '0;
                end
            end else begin
                state_d = ST_SEARCH;
                if (k == '0) begin
                    cand_d = '0;
                    run_d  = '0;
                end else if (k == cand_q && !restart) begin
                    run_d = run_q + 1'b1;
                end else begin
                    cand_d = k;
                    run_d  = PW'(1);
                end

                if (k != '0 && run_d == cand_d) begin
                    state_d  = ST_LOCKED;
                    found_d  = 1'b1;
                    period_d = cand_d;
                    steps_d  = n_cur;
                end
`ifdef ATTRACTOR_TIMEOUT_EN
                else if (n_cur == CNT_W'(MAX_STEPS - 1)) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hv_q      <= '0;
            n_q       <= '0;
            cand_q    <= '0;
            run_q     <= '0;
            found_q   <= 1'b0;
            period_q  <= '0;
            steps_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hv_q      <= hv_d;
            n_q       <= n_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            found_q   <= found_d;
            period_q  <= period_d;
            steps_q   <= steps_d;
            timeout_q <= timeout_d;
        end
    end

    // History data needs no reset: entries are ignored until their valid bit is set.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    assign found  = found_q;
    assign period = period_q;
    assign steps  = steps_q;
    assign busy   = (state_q == ST_SEARCH) || (state_q == ST_LOCKED);

`ifdef ATTRACTOR_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    logic             unused_timeout_q;
    logic [CNT_W-1:0] unused_max_steps;
    assign unused_timeout_q = timeout_q;
    assign unused_max_steps = CNT_W'(MAX_STEPS);
    assign timeout          = 1'b0;
`endif
endmodule

// File: tb/tb_attractor_detector.sv
// Bench for attractor_detector: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_attractor_detector;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 16;
    localparam int MAX_STEPS = 10;
    localparam int PW        = $clog2(DEPTH+1);
`ifdef ATTRACTOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, restart, in_valid;
    logic [WIDTH-1:0] x;
    logic             found, timeout, busy;
    logic [PW-1:0]    period;
    logic [CNT_W-1:0] steps;

    always #5 clk = ~clk;

    attractor_detector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .x(x),
        .found(found), .period(period), .steps(steps), .timeout(timeout), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 search, 2 locked, 3 timed out. q holds the run's samples, newest at back.
    int               m_mode, m_cand, m_run, m_n, m_found, m_period, m_steps, m_timeout;
    logic [WIDTH-1:0] q[$];

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_cand = 0; m_run = 0; m_n = 0;
        m_found = 0; m_period = 0; m_steps = 0; m_timeout = 0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [WIDTH-1:0] xi);
        int k;
        if (r) begin
            model_reset();
            m_mode = 1;
        end
        if (!v || m_mode == 3) return;
        if (m_mode == 0) m_mode = 1;
        if (m_mode == 2) begin
            if (q[q.size() - m_period] != xi) begin
                m_found = 0; m_period = 0; m_cand = 0; m_run = 0; m_mode = 1;
            end
        end else begin
            k = 0;
            for (int j = 1; j <= q.size(); j++)
                if (k == 0 && q[q.size() - j] == xi) k = j;
            if (k == 0) begin
                m_cand = 0; m_run = 0;
            end else if (k == m_cand) begin
                m_run++;
            end else begin
                m_cand = k; m_run = 1;
            end
            if (k != 0 && m_run == m_cand) begin
                m_mode = 2; m_found = 1; m_period = m_cand; m_steps = m_n;
            end else if (TO_EN && m_n == MAX_STEPS - 1) begin
                m_mode = 3; m_timeout = 1;
            end
        end
        q.push_back(xi);
        if (q.size() > DEPTH) void'(q.pop_front());
        if (m_n < (1 << CNT_W) - 1) m_n++;
    endtask

    // Drive one cycle (inputs set after negedge), update the model at the edge, compare at the next negedge.
    task automatic cyc(input logic rs, input logic r, input logic v, input logic [WIDTH-1:0] xi);
        rst = rs; restart = r; in_valid = v; x = xi;
        @(posedge clk);
        if (rs) model_reset();
        else    model_step(r, v, xi);
        @(negedge clk);
        check("found",   found,   m_found);
        check("period",  period,  m_period);
        check("steps",   steps,   m_steps);
        check("timeout", timeout, m_timeout);
        check("busy",    busy,    (m_mode == 1 || m_mode == 2) ? 1 : 0);
    endtask

    task automatic sample(input logic [WIDTH-1:0] xi);
        cyc(1'b0, 1'b0, 1'b1, xi);
    endtask

    task automatic do_restart();
        cyc(1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        logic [WIDTH-1:0] seq[6];
        rst = 1'b1; restart = 1'b0; in_valid = 1'b0; x = '0;
        model_reset();
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check("rst_found", found, 0);
        check("rst_busy", busy, 0);

        // Fixed point
        do_restart();
        sample(8'h05); sample(8'h03); sample(8'h07);
        check("fp_pre_found", found, 0);
        sample(8'h07);
        check("fp_found", found, 1);
        check("fp_period", period, 1);
        check("fp_steps", steps, 3);

        // Period 3 with idle gaps
        do_restart();
        seq = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 6; i++) begin
            sample(seq[i]);
            cyc(1'b0, 1'b0, 1'b0, 8'hFF);
        end
        check("p3_found", found, 1);
        check("p3_period", period, 3);
        check("p3_steps", steps, 5);

        // Lock loss and relock as fixed point
        do_restart();
        sample(8'h0A); sample(8'h0B); sample(8'h0A); sample(8'h0B);
        check("p2_found", found, 1);
        check("p2_period", period, 2);
        sample(8'h0C);
        check("loss_found", found, 0);
        check("loss_period", period, 0);
        sample(8'h0C);
        check("relock_found", found, 1);
        check("relock_period", period, 1);

        // Restart with in_valid mid-run
        do_restart();
        sample(8'h01); sample(8'h02); sample(8'h03);
        cyc(1'b0, 1'b1, 1'b1, 8'h40);
        sample(8'h40);
        check("rs_found", found, 1);
        check("rs_period", period, 1);
        check("rs_steps", steps, 1);

        // Period 5 never locks with DEPTH 4
        do_restart();
        for (int r = 0; r < 4; r++)
            for (int i = 1; i <= 5; i++) sample(WIDTH'(i));
        check("p5_found", found, 0);

`ifdef ATTRACTOR_TIMEOUT_EN
        do_restart();
        for (int i = 0; i < 10; i++) sample(WIDTH'(8'h80 + i));
        check("to_timeout", timeout, 1);
        check("to_busy", busy, 0);
        sample(8'h80); sample(8'h80);
        check("to_hold", timeout, 1);
        do_restart();
        check("to_clear", timeout, 0);
        check("to_rebusy", busy, 1);
`endif

        // rst mid-run clears everything
        do_restart();
        sample(8'h09); sample(8'h09);
        cyc(1'b1, 1'b0, 1'b1, 8'h09);
        check("midrst_found", found, 0);
        check("midrst_steps", steps, 0);

        // Randomized traffic from a small alphabet so locks and losses happen often
        for (int c = 0; c < 600; c++) begin
            logic rs, r, v;
            rs = ($urandom_range(0, 149) == 0);
            r  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 7);
            cyc(rs, r, v, WIDTH'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/attractor_detector.md
# attractor_detector

Parametrised attractor detector for the gene-network simulator: consumes the network state x[t] one sample per accepted cycle, keeps a shift history of the last DEPTH states, and declares an attractor when a fixed point (period 1) or a limit cycle of period 2..DEPTH has repeated for one full period. It sits beside the network update engine, replacing single-step fixed-point flagging. It reports period, transient length and an optional no-convergence timeout.

## Interface
- WIDTH, 8: bits per network state x.
- DEPTH, 8: longest detectable period (history length), >=1.
- CNT_W, 16: width of the step counter.
- MAX_STEPS, 1000: timeout threshold in accepted samples (used only with timeout compiled in).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  new initial value applied; clears run state.
- in_valid  in  1  x is a new network state this cycle.
- x  in  WIDTH  current network state.
- found  out  1  attractor locked.
- period  out  $clog2(DEPTH+1)  locked period (0 when not found).
- steps  out  CNT_W  index of sample at which lock was declared.
- timeout  out  1  MAX_STEPS reached without lock.
- busy  out  1  run active (SEARCH or LOCKED).

## Operation
- History hist[1..DEPTH] with valid bits; hist[1] = previous accepted sample. Accepted sample shifts in at hist[1]; only valid entries are compared.
- Sample index n: 0 for the first accepted sample after rst/restart, +1 per accepted sample, saturating at all-ones.
- Per accepted sample: k = smallest valid index with x == hist[k] (none if no match). If k == cand: run++, else cand = k, run = 1 (run = 0 if no match).
- States: IDLE (after rst; found/period/steps/timeout/busy = 0), SEARCH, LOCKED, TIMEOUT.
- IDLE -> SEARCH on restart or first in_valid.
- SEARCH -> LOCKED when run == cand: found=1, period=cand, steps=n.
- LOCKED: each accepted sample must equal hist[period]; on mismatch found=0, period=0, steps held, cand/run cleared, history kept, -> SEARCH.
- restart in any state: history valid bits, n, cand, run, found, period, steps, timeout cleared; -> SEARCH. If in_valid is also high, restart takes priority and that sample is accepted as index 0 of the new run.
- Periods > DEPTH never lock.
- rst overrides restart and in_valid.

## Timing
- One sample per clock max; in_valid low cycles change nothing.
- Lock latency: found/period/steps update at the same posedge that accepts the locking sample; visible the following cycle.
- Fixed point: earliest lock at index 1. Period p: earliest lock at index 2p-1.
- Lock loss deasserts found at the posedge accepting the mismatching sample.
- rst mid-run: all outputs 0 the cycle after the rst edge.

## Configuration
- ATTRACTOR_TIMEOUT_EN defined: in SEARCH, when an accepted sample has n == MAX_STEPS-1 and no lock results, timeout=1, busy=0, -> TIMEOUT; samples ignored until restart or rst. Lock on that same sample wins over timeout.
- Not defined: no timeout logic; timeout tied 0; SEARCH runs indefinitely (n saturates).

## Test plan
- Fixed point: restart, samples 0x05,0x03,0x07,0x07 -> found=1, period=1, steps=3 one cycle after 4th sample.
- Period 3 with gaps: 0x11,0x22,0x33,0x11,0x22,0x33 with in_valid low every other cycle -> found=1, period=3, steps=5; no change on idle cycles.
- Lock loss: after period-2 lock on 0xA,0xB,0xA,0xB, send 0xC -> found=0, period=0; then 0xC -> found=1, period=1.
- Restart mid-run with in_valid: after 3 samples, restart+in_valid x=0x40, then 0x40 -> found=1, period=1, steps=1.
- Over-depth cycle: DEPTH=4, period-5 sequence repeated 4 times -> found stays 0.
- Timeout (macro on, MAX_STEPS=10): 10 distinct samples -> timeout=1, busy=0 after 10th; further samples ignored; restart clears timeout.
